fifo_uart_tx: RTL and testbench

UART 8N1-style transmitter that drains the byte FIFO from the read side, using that FIFO's pop / registered-pop_data handshake. It pulls one byte per frame, serialises it LSB-first on tx, and stalls while the FIFO is empty or tx_enable is low. It sits between the PC-side FIFO and the tx pin, in the return path to the host (status, acks).

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_gen.sv | 40 ++++
 rtl/fifo_uart_tx.sv | 158 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } tx_state_t;

  // Clock cycles per bit; truncating division, caller guarantees result >= 2.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..DIV-1 and flags the last cycle of each bit.
module uart_baud_gen #(
  parameter int DIV = 868
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: hold at zero while cleared, wrap after the last cycle of a bit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1-style UART transmitter that pulls bytes from a registered-read FIFO.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  input  logic [DATA_WIDTH-1:0] fifo_pop_data,
  input  logic                  tx_enable,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  frame_done
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int BW  = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  tx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  tx_q, tx_d;
  logic                  pop_q, pop_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  baud_clear_s;
  logic                  tick_s;

  uart_baud_gen #(
    .DIV (DIV)
  ) u_baud (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clear_i (baud_clear_s),
    .tick_o  (tick_s)
  );

  // Frame sequencing; outputs are precomputed from the next state so the
  // registered pins line up with the state register.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_d        = bit_q;
    done_d       = 1'b0;
    baud_clear_s = 1'b0;
    case (state_q)
      IDLE: begin
        baud_clear_s = 1'b1;
        if (tx_enable && !fifo_empty) begin
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        baud_clear_s = 1'b1;
        state_d      = LOAD;
      end
      LOAD: begin
        // Read data is valid now, one cycle after the pop.
        baud_clear_s = 1'b1;
        shift_d      = fifo_pop_data;
        bit_d        = '0;
        state_d      = START;
      end
      START: begin
        if (tick_s) begin
          bit_d   = '0;
          state_d = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          shift_d = shift_q >> 1'b1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + BW'(1);
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        // bit_q counts stop bits here.
        if (tick_s) begin
          if (bit_q == STOP_LAST) begin
            done_d = 1'b1;
            bit_d  = '0;
            if (tx_enable && !fifo_empty) begin
              state_d = FETCH;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d   = bit_q + BW'(1);
            state_d = STOP;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        baud_clear_s = 1'b1;
        state_d      = IDLE;
      end
    endcase
  end

  // Pin values for the upcoming state.
  always_comb begin
    pop_d  = (state_d == FETCH);
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State, datapath and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      pop_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      pop_q   <= pop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx         = tx_q;
  assign fifo_pop   = pop_q;
  assign tx_busy    = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed, scoreboard-based bench for fifo_uart_tx (DIV = 10).
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  int         checks = 0;
  int         fails = 0;
  int         cyc = 0;

  // DUT 1: STOP_BITS = 1, fed by a queue-style FIFO model.
  logic       tx_enable = 1'b0;
  logic       fifo_empty;
  logic       fifo_pop;
  logic [7:0] fifo_pop_data = 8'h00;
  logic       tx, tx_busy, frame_done;
  logic [7:0] mem [0:63];
  int         wr_cnt = 0;
  int         rd_cnt = 0;

  // DUT 2: STOP_BITS = 2, single-byte source.
  logic       en2 = 1'b0;
  logic       empty2;
  logic       pop2;
  logic [7:0] pd2 = 8'h00;
  logic       tx2, busy2, done2;
  int         pop2_cnt = 0;

  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  assign fifo_empty = (wr_cnt == rd_cnt);
  assign empty2     = (pop2_cnt != 0);

  fifo_uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
    .fifo_pop_data(fifo_pop_data), .tx_enable(tx_enable), .tx(tx),
    .tx_busy(tx_busy), .frame_done(frame_done)
  );

  fifo_uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .fifo_empty(empty2), .fifo_pop(pop2),
    .fifo_pop_data(pd2), .tx_enable(en2), .tx(tx2),
    .tx_busy(busy2), .frame_done(done2)
  );

  // Cycle counter and FIFO read ports (registered read data).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_pop) begin
      fifo_pop_data <= mem[rd_cnt % 64];
      rd_cnt <= rd_cnt + 1;
    end
    if (pop2) begin
      pd2 <= 8'h55;
      pop2_cnt <= pop2_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_cnt % 64] = b;
    wr_cnt++;
    exp_q.push_back(b);
  endtask

  function automatic logic tx_of(input int sel);
    return (sel != 0) ? tx2 : tx;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel != 0) ? done2 : frame_done;
  endfunction

  // Wait for a start bit, pop the expected byte and check the whole waveform.
  task automatic rx_frame(input int sel, input int stops, output int start_cyc);
    int         len, waited, bad_tx, bad_done;
    logic [7:0] exp, got;
    logic       e;
    len = (1 + 8 + stops) * 10;
    waited = 0; bad_tx = 0; bad_done = 0; got = 8'h00; start_cyc = -1;
    while (tx_of(sel) !== 1'b0 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    chk("start_timeout", (waited < 2000), 1);
    if (waited >= 2000) return;
    start_cyc = cyc;
    chk("scoreboard_nonempty", (exp_q.size() != 0), 1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    for (int n = 0; n <= len; n++) begin
      if (n < 10) e = 1'b0;
      else if (n < 90) e = exp[(n - 10) / 10];
      else e = 1'b1;
      if (n < len && tx_of(sel) !== e) bad_tx++;
      if (done_of(sel) !== ((n == len) ? 1'b1 : 1'b0)) bad_done++;
      if (n >= 10 && n < 90 && (n % 10) == 5) got[(n - 10) / 10] = tx_of(sel);
      if (n < len) @(negedge clk);
    end
    chk("frame_wave", bad_tx, 0);
    chk("frame_done_timing", bad_done, 0);
    chk("frame_data", got, exp);
  endtask

  initial begin
    int s1, s2, pops0, bad, waited;

    // Reset state.
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_pop", fifo_pop, 0);
    chk("rst_done", frame_done, 0);
    reset = 1'b1;

    // Empty FIFO with permission: nothing moves.
    tx_enable = 1'b1;
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_pop !== 1'b0 || tx_busy !== 1'b0) bad++;
    end
    chk("empty_idle", bad, 0);

    // Single byte 0xA5.
    pops0 = rd_cnt;
    push(8'hA5);
    @(negedge clk);
    chk("single_pop_pulse", fifo_pop, 1);
    chk("single_busy", tx_busy, 1);
    @(negedge clk);
    chk("single_pop_once", fifo_pop, 0);
    rx_frame(0, 1, s1);
    chk("single_busy_clear", tx_busy, 0);
    chk("single_pop_count", rd_cnt - pops0, 1);

    // Back-to-back 0x00, 0xFF.
    pops0 = rd_cnt;
    push(8'h00);
    push(8'hFF);
    rx_frame(0, 1, s1);
    rx_frame(0, 1, s2);
    chk("b2b_high_gap", s2 - (s1 + 90), 12);
    chk("b2b_pop_count", rd_cnt - pops0, 2);
    chk("b2b_fifo_empty", fifo_empty, 1);
    chk("b2b_busy_clear", tx_busy, 0);

    // tx_enable dropped mid-frame of 0x3C.
    pops0 = rd_cnt;
    push(8'h3C);
    push(8'h99);
    fork
      rx_frame(0, 1, s1);
      begin
        repeat (40) @(negedge clk);
        tx_enable = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    chk("gate_pop_count", rd_cnt - pops0, 1);
    chk("gate_idle_busy", tx_busy, 0);
    chk("gate_fifo_nonempty", fifo_empty, 0);
    tx_enable = 1'b1;
    @(negedge clk);
    chk("gate_refetch", fifo_pop, 1);
    rx_frame(0, 1, s1);

    // Async reset in data bit 4 of 0x81.
    push(8'h81);
    waited = 0;
    while (tx !== 1'b0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("rst_mid_start", (waited < 200), 1);
    repeat (55) @(negedge clk);
    chk("rst_mid_bit4_low", tx, 0);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_tx_async", tx, 1);
    chk("rst_mid_busy", tx_busy, 0);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || tx !== 1'b1) bad++;
    end
    chk("rst_mid_hold", bad, 0);
    push(8'h5A);
    reset = 1'b1;
    rx_frame(0, 1, s1);

    // Two stop bits on the second instance with 0x55.
    exp_q.push_back(8'h55);
    @(negedge clk);
    en2 = 1'b1;
    rx_frame(1, 2, s1);
    chk("stop2_busy_clear", busy2, 0);
    chk("stop2_pop_count", pop2_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
